// File: rtl/fifo_param_ctrl_if.sv
// Handshake and status bundle between a FIFO client and fifo_param_ctrl.
// The master drives requests and thresholds; the slave side is the FIFO itself.
interface fifo_param_ctrl_if #(
    parameter int WORD_SIZE = 10,
    parameter int PTR       = 3
);
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic [WORD_SIZE-1:0] fifo_data_in;
    logic [PTR-1:0]       full_threshold;
    logic [PTR-1:0]       empty_threshold;
    logic                 err_clr;
    logic [WORD_SIZE-1:0] fifo_data_out;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [PTR:0]         fifo_count;
    logic [1:0]           error;

    modport master (
        output fifo_wr, fifo_rd, fifo_data_in, full_threshold, empty_threshold, err_clr,
        input  fifo_data_out, fifo_full, fifo_empty, almost_full, almost_empty, fifo_count, error
    );

    modport slave (
        input  fifo_wr, fifo_rd, fifo_data_in, full_threshold, empty_threshold, err_clr,
        output fifo_data_out, fifo_full, fifo_empty, almost_full, almost_empty, fifo_count, error
    );
endinterface

// File: rtl/fifo_param_ctrl.sv
// Parametrised synchronous FIFO with threshold flags, occupancy count and sticky errors.
// Latency: FWFT=0 read data one cycle after rd; FWFT=1 head word visible the cycle after its write.
// Backpressure: writes to a full FIFO are dropped (overflow), reads of an empty FIFO ignored (underflow).
module fifo_param_ctrl #(
    parameter int WORD_SIZE = 10,
    parameter int MEM_SIZE  = 8,
    parameter int PTR       = 3,
    parameter int FWFT      = 0
) (
    input logic              clk,
    input logic              reset,
    fifo_param_ctrl_if.slave bus
);
    localparam logic [PTR:0]   FULL_CNT = (PTR+1)'(MEM_SIZE);
    localparam logic [PTR:0]   CNT_ONE  = (PTR+1)'(1);
    localparam logic [PTR-1:0] PTR_ONE  = PTR'(1);

    logic [WORD_SIZE-1:0] mem [MEM_SIZE];
    logic [PTR-1:0]       wr_ptr;
    logic [PTR-1:0]       rd_ptr;
    logic [PTR:0]         count;
    logic [1:0]           error_q;
    logic                 full;
    logic                 empty;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 ovf;
    logic                 unf;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign rd_acc = bus.fifo_rd & ~empty;
    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign wr_acc = bus.fifo_wr & (~full | rd_acc);
    assign ovf    = bus.fifo_wr & full & ~rd_acc;
    assign unf    = bus.fifo_rd & empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            error_q <= 2'b00;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A new fault in the same cycle as err_clr leaves its bit set.
            error_q <= (bus.err_clr ? 2'b00 : error_q) | {ovf, unf};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !reset) mem[wr_ptr] <= bus.fifo_data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.fifo_data_out = mem[rd_ptr];
        end else begin : g_reg
            logic [WORD_SIZE-1:0] dout_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)       dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr];
            end
            assign bus.fifo_data_out = dout_q;
        end
    endgenerate

    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.fifo_count   = count;
    assign bus.error        = error_q;
    assign bus.almost_full  = (bus.full_threshold != '0) &&
                              (count >= {1'b0, bus.full_threshold}) && !full;
    assign bus.almost_empty = !empty && (count <= {1'b0, bus.empty_threshold});
endmodule

// File: tb/tb_fifo_param_ctrl.sv
// Drives a registered-output and an FWFT instance with identical stimulus and checks both
// against a queue-based model every cycle, plus directed scenarios with literal expectations.
module tb_fifo_param_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_param_ctrl_if #(.WORD_SIZE(10), .PTR(3)) if0 ();
    fifo_param_ctrl_if #(.WORD_SIZE(10), .PTR(3)) if1 ();

    fifo_param_ctrl #(.WORD_SIZE(10), .MEM_SIZE(8), .PTR(3), .FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .bus(if0.slave));
    fifo_param_ctrl #(.WORD_SIZE(10), .MEM_SIZE(8), .PTR(3), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .bus(if1.slave));

    int checks = 0;
    int errors = 0;
    bit run_chk = 0;

    // Model: the FIFO contents as a queue, sticky error bits, last word read out.
    logic [9:0] mq[$];
    logic [1:0] m_err;
    logic [9:0] m_dout0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_err   = 2'b00;
        m_dout0 = '0;
    endtask

    task automatic drive(input bit wr, input bit rd, input logic [9:0] d, input bit clr);
        if0.fifo_wr = wr; if0.fifo_rd = rd; if0.fifo_data_in = d; if0.err_clr = clr;
        if1.fifo_wr = wr; if1.fifo_rd = rd; if1.fifo_data_in = d; if1.err_clr = clr;
    endtask

    task automatic set_thr(input logic [2:0] ft, input logic [2:0] et);
        if0.full_threshold = ft; if0.empty_threshold = et;
        if1.full_threshold = ft; if1.empty_threshold = et;
    endtask

    // One clock: present inputs, advance the model over the edge, return just after it.
    task automatic cycle(input bit wr, input bit rd, input logic [9:0] d, input bit clr);
        bit rd_acc, wr_acc, ovf, unf;
        int n;
        drive(wr, rd, d, clr);
        n      = mq.size();
        rd_acc = rd && (n > 0);
        wr_acc = wr && ((n < 8) || rd_acc);
        ovf    = wr && (n == 8) && !rd_acc;
        unf    = rd && (n == 0);
        @(posedge clk);
        if (rd_acc) m_dout0 = mq.pop_front();
        if (wr_acc) mq.push_back(d);
        m_err = (clr ? 2'b00 : m_err) | {ovf, unf};
        #1;
    endtask

    task automatic chk_dut(input string tag, input logic [3:0] cnt, input logic full,
                           input logic empty, input logic af, input logic ae,
                           input logic [1:0] err, input logic [9:0] dout, input bit fwft);
        int n, ft, et;
        n  = mq.size();
        ft = int'(if0.full_threshold);
        et = int'(if0.empty_threshold);
        chk({tag, "_count"}, cnt, n);
        chk({tag, "_full"}, full, n == 8);
        chk({tag, "_empty"}, empty, n == 0);
        chk({tag, "_afull"}, af, (ft != 0) && (n >= ft) && (n != 8));
        chk({tag, "_aempty"}, ae, (n != 0) && (n <= et));
        chk({tag, "_error"}, err, m_err);
        if (!fwft)       chk({tag, "_dout"}, dout, m_dout0);
        else if (n > 0)  chk({tag, "_dout"}, dout, mq[0]);
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            chk_dut("reg", if0.fifo_count, if0.fifo_full, if0.fifo_empty, if0.almost_full,
                    if0.almost_empty, if0.error, if0.fifo_data_out, 1'b0);
            chk_dut("fwft", if1.fifo_count, if1.fifo_full, if1.fifo_empty, if1.almost_full,
                    if1.almost_empty, if1.error, if1.fifo_data_out, 1'b1);
        end
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, '0, 0);
        set_thr(3'd6, 3'd2);
        model_reset();
        #1;
        chk("rst_count", if0.fifo_count, 0);
        chk("rst_empty", if0.fifo_empty, 1);
        chk("rst_full", if0.fifo_full, 0);
        chk("rst_afull", if0.almost_full, 0);
        chk("rst_aempty", if0.almost_empty, 0);
        chk("rst_error", if0.error, 0);
        chk("rst_dout", if0.fifo_data_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset   = 1'b0;
        run_chk = 1;

        // Fill with 0x001..0x008.
        for (int k = 1; k <= 8; k++) begin
            cycle(1, 0, 10'(k), 0);
            chk("fill_count", if0.fifo_count, k);
            chk("fill_afull", if0.almost_full, (k >= 6) && (k <= 7));
        end
        chk("fill_full", if0.fifo_full, 1);

        // Overflow, then drain in order.
        cycle(1, 0, 10'h3FF, 0);
        chk("ovf_error", if0.error, 2'b10);
        chk("ovf_count", if0.fifo_count, 8);
        for (int k = 1; k <= 8; k++) begin
            chk("drain_fwft_head", if1.fifo_data_out, k);
            cycle(0, 1, '0, 0);
            chk("drain_data", if0.fifo_data_out, k);
        end
        chk("drain_empty", if0.fifo_empty, 1);

        // Underflow ORs into the sticky bits; data holds; clear.
        cycle(0, 1, '0, 0);
        chk("unf_error", if0.error, 2'b11);
        chk("unf_dout_hold", if0.fifo_data_out, 10'h008);
        cycle(0, 0, '0, 1);
        chk("clr_error", if0.error, 2'b00);

        // Full with simultaneous wr/rd across the pointer wrap.
        for (int k = 0; k < 8; k++) cycle(1, 0, 10'(12'h100 + k), 0);
        for (int j = 0; j < 10; j++) begin
            cycle(1, 1, 10'(12'h200 + j), 0);
            chk("wrap_count", if0.fifo_count, 8);
            chk("wrap_error", if0.error, 2'b00);
            chk("wrap_data", if0.fifo_data_out, (j < 8) ? (32'h100 + j) : (32'h200 + j - 8));
        end

        // FWFT: single word appears without a read, one read empties.
        for (int k = 0; k < 8; k++) cycle(0, 1, '0, 0);
        cycle(1, 0, 10'h155, 0);
        chk("fwft_head", if1.fifo_data_out, 10'h155);
        chk("fwft_nonempty", if1.fifo_empty, 0);
        cycle(0, 1, '0, 0);
        chk("fwft_empty", if1.fifo_empty, 1);
        chk("reg_read_155", if0.fifo_data_out, 10'h155);

        // Asynchronous reset mid-burst with a pending write.
        cycle(0, 1, '0, 0);
        for (int k = 0; k < 5; k++) cycle(1, 0, 10'(12'h0A0 + k), 0);
        chk("pre_rst_count", if0.fifo_count, 5);
        chk("pre_rst_error", if0.error, 2'b01);
        drive(1, 0, 10'h3AB, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_count", if0.fifo_count, 0);
        chk("mid_rst_empty", if0.fifo_empty, 1);
        chk("mid_rst_error", if0.error, 0);
        chk("mid_rst_count_fwft", if1.fifo_count, 0);
        @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        drive(0, 0, '0, 0);
        chk("post_rst_count", if0.fifo_count, 0);

        // Randomised traffic with varying bias and thresholds.
        for (int i = 0; i < 1500; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 70 : 35;
            if ($urandom_range(0, 19) == 0)
                set_thr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                  10'($urandom), $urandom_range(0, 19) == 0);
        end
        drive(0, 0, '0, 0);
        @(negedge clk);
        run_chk = 0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
